cache_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and transaction sequencer in front of the shared cache_and_ram datapath. It accepts read/write requests from master 0 and master 1, with master 0 typically the fetch side and master 1 the load/store side. It issues one transaction at a time to the cache port and waits for completion with a timeout watchdog. It then routes the response back to the owning master.

---
 rtl/cache_arb_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/cache_port_arbiter.sv | 130 +++++++++++++
 tb/tb_cache_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and constants for the cache port arbiter
package cache_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT = 16;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin winner select with last-grant memory
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant_en,
    output logic o_any,
    output logic o_winner
);
    logic r_last_grant;

    assign o_any    = i_req0 | i_req1;
    // On a tie the master that did not win last time gets the port.
    assign o_winner = (i_req0 && i_req1) ? ~r_last_grant : i_req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= OWNER_M1;
        end else if (i_grant_en && o_any) begin
            r_last_grant <= o_winner;
        end
    end
endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-master arbiter and single-transaction sequencer for the cache port
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rsp_valid,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cache_req,
    output logic              cache_mode,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic              cache_done,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_abort,
    output logic              busy
);
    arb_state_t        r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_cache_req;
    logic              r_rsp_valid;
    logic [CNT_W-1:0]  r_wd;

    logic w_any;
    logic w_winner;
    logic w_grant;
    logic w_timeout;

    // Grant is same-cycle; masked by rst so nothing leaks out while reset is held.
    assign w_grant   = rst && (r_state == IDLE) && w_any;
    assign w_timeout = (r_state == WAIT) && !cache_done && (r_wd == CNT_W'(TIMEOUT - 1));

    rr_arbiter2 u_rr_arbiter2 (
        .clk        (clk),
        .rst        (rst),
        .i_req0     (m0_req),
        .i_req1     (m1_req),
        .i_grant_en (w_grant),
        .o_any      (w_any),
        .o_winner   (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= OWNER_M0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cache_req <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_wd        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_winner;
                        r_we        <= w_winner ? m1_we    : m0_we;
                        r_addr      <= w_winner ? m1_addr  : m0_addr;
                        r_wdata     <= w_winner ? m1_wdata : m0_wdata;
                        r_cache_req <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cache_req <= 1'b0;
                    r_wd        <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (cache_done) begin
                        r_rdata     <= r_we ? '0 : cache_rdata;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_wd <= r_wd + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m0_gnt       = w_grant && (w_winner == OWNER_M0);
    assign m1_gnt       = w_grant && (w_winner == OWNER_M1);
    assign m0_rsp_valid = r_rsp_valid && (r_owner == OWNER_M0);
    assign m1_rsp_valid = r_rsp_valid && (r_owner == OWNER_M1);
    assign rsp_rdata    = (r_state == RESP) ? r_rdata : '0;
    assign rsp_err      = (r_state == RESP) ? r_err : 1'b0;
    assign cache_req    = r_cache_req;
    assign cache_mode   = r_we;
    assign cache_addr   = r_addr;
    assign cache_wdata  = r_wdata;
    assign cache_abort  = w_timeout;
    assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - randomized transaction-level check of cache_port_arbiter
module tb_cache_port_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, cache_addr, cache_wdata;
    logic        cache_req, cache_mode, cache_abort, busy;
    logic        cache_done = 1'b0;
    logic [31:0] cache_rdata = '0;

    cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rsp_valid(m0_rsp_valid), .m1_rsp_valid(m1_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cache_req(cache_req), .cache_mode(cache_mode),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_done(cache_done), .cache_rdata(cache_rdata),
        .cache_abort(cache_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pending request of each master and the model's notion of who won last.
    bit          p_req[2];
    bit          p_we[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    int          exp_last = 1;
    int          order_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
        m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    endtask

    task automatic newreq(input int m);
        p_req[m]   = 1'b1;
        p_we[m]    = 1'($urandom_range(0, 1));
        p_addr[m]  = $urandom;
        p_wdata[m] = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full transaction starting in IDLE. k = WAIT-cycle index of cache_done; k >= TO means never.
    task automatic run_txn(input int k, input bit early, input logic [31:0] rd, input bit keep);
        int          w;
        bit          we;
        logic [31:0] a, wd;
        bit          timed_out;
        timed_out = (k >= TO);
        cache_done = 1'b0;
        drive();
        w = (p_req[0] && p_req[1]) ? 1 - exp_last : (p_req[0] ? 0 : 1);
        @(negedge clk);
        chk("gnt0", m0_gnt, w == 0);
        chk("gnt1", m1_gnt, w == 1);
        chk("busy_idle", busy, 0);
        exp_last = w;
        order_q.push_back(w);
        we = p_we[w]; a = p_addr[w]; wd = p_wdata[w];
        p_req[w] = 1'b0;
        if (keep || $urandom_range(0, 1) == 1) newreq(w);

        tick();
        drive();
        cache_done  = early;
        cache_rdata = $urandom;
        @(negedge clk);
        chk("issue_req", cache_req, 1);
        chk("issue_mode", cache_mode, we);
        chk("issue_addr", cache_addr, a);
        chk("issue_wdata", cache_wdata, wd);
        chk("issue_gnt", {m0_gnt, m1_gnt}, 0);
        chk("issue_busy", busy, 1);

        for (int c = 0; c < TO; c++) begin
            tick();
            cache_done  = (c == k);
            cache_rdata = (c == k) ? rd : $urandom;
            @(negedge clk);
            chk("wait_req", cache_req, 0);
            chk("wait_abort", cache_abort, timed_out && (c == TO - 1));
            chk("wait_gnt", {m0_gnt, m1_gnt}, 0);
            chk("wait_rsp", {m0_rsp_valid, m1_rsp_valid, rsp_err}, 0);
            chk("wait_rdata", rsp_rdata, 0);
            chk("wait_hold", {cache_mode, cache_addr, cache_wdata}, {we, a, wd});
            if (c == k) break;
        end

        tick();
        cache_done  = 1'b0;
        cache_rdata = $urandom;
        @(negedge clk);
        chk("rsp0", m0_rsp_valid, w == 0);
        chk("rsp1", m1_rsp_valid, w == 1);
        chk("rsp_rdata", rsp_rdata, (!timed_out && !we) ? rd : 32'h0);
        chk("rsp_err", rsp_err, timed_out);
        chk("rsp_abort", cache_abort, 0);
        chk("rsp_gnt", {m0_gnt, m1_gnt}, 0);
        tick();
    endtask

    task automatic idle_cycle(input bit late_done);
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        drive();
        cache_done  = late_done;
        cache_rdata = $urandom;
        @(negedge clk);
        chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rsp", {m0_rsp_valid, m1_rsp_valid, rsp_err, cache_abort, cache_req}, 0);
        chk("idle_rdata", rsp_rdata, 0);
        tick();
        cache_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, rsp_err, cache_req,
                  cache_mode, cache_abort, busy}, 0);
        chk({tag, "_data"}, {rsp_rdata, cache_addr, cache_wdata}, 0);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 0; p_we[m] = 0; p_addr[m] = '0; p_wdata[m] = '0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // m0 read alone, done at the earliest point
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 32'h40; p_wdata[0] = 32'h0;
        run_txn(0, 0, 32'hDEADBEEF, 0);
        idle_cycle(0);

        // m1 write
        p_req[1] = 1; p_we[1] = 1; p_addr[1] = 32'h1004; p_wdata[1] = 32'h12345678;
        run_txn(2, 0, 32'hCAFEF00D, 0);
        idle_cycle(0);

        // both requesting continuously: strict alternation starting with m0
        order_q.delete();
        newreq(0); newreq(1);
        for (int i = 0; i < 4; i++) run_txn($urandom_range(0, 3), 0, $urandom, 1);
        for (int i = 0; i < 4; i++) chk("alt_order", order_q[i], i % 2);
        idle_cycle(0);

        // timeout with a late done arriving in IDLE
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 32'h80;
        run_txn(TO, 0, 32'h11111111, 0);
        idle_cycle(1);

        // done in ISSUE ignored, real done 5 cycles later
        p_req[1] = 1; p_we[1] = 0; p_addr[1] = 32'h2000;
        run_txn(4, 1, 32'hA5A5A5A5, 0);
        idle_cycle(0);

        // reset while in WAIT
        newreq(0); newreq(1);
        drive();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        check_all_zero("rst_hold");
        tick();
        rst = 1'b1;
        exp_last = 1;
        p_req[0] = 1; p_req[1] = 1;
        order_q.delete();
        run_txn(1, 0, 32'h5555AAAA, 0);
        chk("post_rst_tie", order_q[0], 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
            if (!p_req[0] && !p_req[1]) newreq($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                if (!p_req[0]) newreq(0);
                else if (!p_req[1]) newreq(1);
            end
            run_txn($urandom_range(0, TO + 2), ($urandom_range(0, 3) == 0), $urandom, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
